start_edge_monitor: RTL and testbench
=====================================

# start_edge_monitor

Synthesizable counterpart to the start-pulse assertion checks used in our benches. Samples a level `start` signal, detects rising edges with `$rose` semantics, keeps a running edge count, and measures the clock-cycle period between consecutive edges. Each edge is reported as an event record on a valid/ready interface, so downstream logic consumes in hardware what the assertion otherwise reports only in simulation.

## Interface
Parameters:
- `CNT_W`, 8: width of the edge counter and `evt_count`.
- `PER_W`, 16: width of the period counter and `evt_period`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  monitored level signal.
- `clr`  in  1  synchronous clear of counts, state and overrun.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_valid`  out  1  event record held.
- `evt_count`  out  CNT_W  edge number of the held event.
- `evt_period`  out  PER_W  cycles since the previous edge; 0 for the first edge.
- `rise`  out  1  one-cycle pulse per detected edge.
- `total_count`  out  CNT_W  running edge count.
- `overrun`  out  1  sticky; an event was dropped.

## Operation
- `start_d` is the sampled start. It is either `start` directly or the synchronizer output.
- `prev` is the registered copy of `start_d`.
- An edge is detected when `start_d && !prev`.
- On an edge:
  - `total_count` increments, wrapping modulo 2^CNT_W.
  - `rise` asserts for one cycle.
  - An event is offered with `count` equal to the new `total_count` value.
- FSM states:
  - **S_IDLE:** no edge seen since reset or `clr`. The period counter is held at 0. On the first edge, offer the event with period 0 and go to S_RUN.
  - **S_RUN:** the period counter `per_cnt` runs. On each edge, the offered period equals `per_cnt`, then `per_cnt` loads 1. Otherwise `per_cnt` increments and saturates at 2^PER_W−1.
- Event register (one entry):
  - A handshake completes when `evt_valid && evt_ready`.
  - The offered event is loaded if the register is empty, or if a handshake completes in the same cycle.
  - Otherwise the offered event is dropped and `overrun` sets.
  - When the register empties with no new edge, `evt_valid` drops.
- Clear (`clr=1`):
  - FSM goes to S_IDLE.
  - `total_count`, `per_cnt`, `evt_valid` and `overrun` clear.
  - `rise` is 0.
  - An edge in the same cycle is ignored.
  - `prev` still updates, so a `start` that stays high after `clr` does not produce an edge.
- Reset values: all outputs 0, `prev` = 0, FSM = S_IDLE. A `start` sampled high in the first cycle after reset counts as an edge.
- Reset mid-operation discards a held event without a handshake.

## Timing
- Latency: `start` sampled high at posedge k (with `prev` = 0) gives `rise`, `total_count` and `evt_valid` updated at posedge k+1.
- `evt_period` for edges detected at edges k and k+N equals N. Minimum N is 2, because `start` must be sampled low in between.
- `evt_valid` holds, with the record stable, until a handshake. The record must not change while `evt_valid && !evt_ready`.
- `evt_ready` is ignored when `evt_valid=0`.
- `overrun` sets in the cycle after the dropped edge. It clears only via `clr` or reset.

## Configuration
- `START_SYNC_EN` defined: `start` passes through a two-flop synchronizer, reset to 0, before edge detection. All `start`-to-output latencies grow by 2 cycles; periods are unchanged.
- `START_SYNC_EN` undefined: `start` is assumed synchronous to `clk` and sampled directly.

## Structure
- Package `start_mon_pkg`:
  - FSM enum `mon_state_t` {S_IDLE, S_RUN}.
  - Default `CNT_W` and `PER_W` localparams.
  - Packed struct `mon_evt_t` {count, period}.
- Sub-module `sync_2ff`: generic 1-bit two-flop synchronizer with synchronous active-low reset. Instantiated only under `START_SYNC_EN`.

## Test plan
- **Periodic start:** `start` toggles every 2 cycles (period 4), `evt_ready`=1 → events are (1,0), (2,4), (3,4), ... with `rise` pulsing every 4 cycles and `overrun`=0.
- **Backpressure:** `evt_ready`=0 across 3 edges → `evt_valid` holds (1,0) and `overrun`=1. Then `evt_ready`=1 → handshake completes, and the next edge yields (4,4).
- **Simultaneous:** an edge coincides with a handshake on the held event → the new record loads, `evt_valid` stays 1, `overrun` stays 0.
- **Wrap and saturation:**
  - With CNT_W=4, 17 edges → `total_count`=1 after wrap.
  - With PER_W=4, a gap of 20 cycles → `evt_period`=15.
- **Clear:** `clr` pulsed while `start`=1 and an event is held → all outputs 0. No edge until `start` goes low then high, which yields (1,0).
- **Reset with START_SYNC_EN:** `start`=1 from reset release → `rise` at cycle 3 rather than cycle 1. Mid-run `rst_n`=0 → all outputs 0 the next cycle.

Source files
------------

// File: rtl/start_mon_pkg.sv
// -----------------------------------------------------------------------------
// start_mon_pkg
// Shared types and defaults for the start edge monitor.
//   mon_state_t : monitor FSM states
//   DEF_CNT_W   : default width of the edge counter
//   DEF_PER_W   : default width of the period counter
//   mon_evt_t   : event record {count, period} at the default widths
// -----------------------------------------------------------------------------
package start_mon_pkg;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_PER_W = 16;

   typedef enum logic {
      S_IDLE = 1'b0,   // no edge seen since reset or clear
      S_RUN  = 1'b1    // period counter running
   } mon_state_t;

   typedef struct packed {
      logic [DEF_CNT_W-1:0] count;
      logic [DEF_PER_W-1:0] period;
   } mon_evt_t;

endpackage

// File: rtl/start_edge_monitor_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit two-flop synchronizer, synchronous active-low reset to 0.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/start_edge_monitor.sv
// -----------------------------------------------------------------------------
// start_edge_monitor
// Detects rising edges of a level 'start' signal, counts them, measures the
// cycle distance between consecutive edges, and presents each edge as an event
// record on a valid/ready interface with a single-entry holding register.
// Optional macro START_SYNC_EN: passes 'start' through a two-flop synchronizer
// before edge detection (adds 2 cycles of latency, periods unchanged).
// Ports:
//   clk         : clock, all logic on posedge
//   rst_n       : synchronous active-low reset
//   start       : monitored level signal
//   clr         : synchronous clear of counts, FSM state and overrun
//   evt_ready   : consumer accepts the held event
//   evt_valid   : event record held
//   evt_count   : edge number of the held event
//   evt_period  : cycles since previous edge (0 for the first edge)
//   rise        : one-cycle pulse per detected edge
//   total_count : running edge count (wraps)
//   overrun     : sticky, an event was dropped
// -----------------------------------------------------------------------------
module start_edge_monitor
   import start_mon_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int PER_W = DEF_PER_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clr,
   input  logic             evt_ready,
   output logic             evt_valid,
   output logic [CNT_W-1:0] evt_count,
   output logic [PER_W-1:0] evt_period,
   output logic             rise,
   output logic [CNT_W-1:0] total_count,
   output logic             overrun
);

   localparam logic [PER_W-1:0] PER_MAX = '1;

   logic             start_d;
   logic             prev;
   logic             edge_det;
   logic             hs;
   logic [CNT_W-1:0] cnt_nx;
   logic [PER_W-1:0] per_cnt;
   logic [PER_W-1:0] per_nx;
   logic [PER_W-1:0] offer_period;
   mon_state_t       state;
   mon_state_t       state_nx;

`ifdef START_SYNC_EN
   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (start),
      .q     (start_d)
   );
`else
   assign start_d = start;
`endif

   assign edge_det = start_d & ~prev;
   assign hs       = evt_valid & evt_ready;
   assign cnt_nx   = total_count + CNT_W'(1);

   // FSM state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state   <= S_IDLE;
         per_cnt <= '0;
      end else begin
         state   <= state_nx;
         per_cnt <= per_nx;
      end
   end

   // Next state and period counter. The period of an edge is the value the
   // counter holds when the edge arrives; reloading 1 on the edge itself makes
   // edges N cycles apart report exactly N.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_nx     = state;
      per_nx       = per_cnt;
      offer_period = '0;
      case (state)
         S_IDLE: begin
            per_nx = '0;
            if (edge_det) begin
               state_nx = S_RUN;
               per_nx   = PER_W'(1);
            end
         end
         S_RUN: begin
            if (edge_det) begin
               offer_period = per_cnt;
               per_nx       = PER_W'(1);
            end else if (per_cnt != PER_MAX) begin
               per_nx = per_cnt + PER_W'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
            per_nx   = '0;
         end
      endcase
      if (clr) begin
         state_nx = S_IDLE;
         per_nx   = '0;
      end
   end

   // Edge history, counters and the single-entry event register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev        <= 1'b0;
         rise        <= 1'b0;
         total_count <= '0;
         evt_valid   <= 1'b0;
         evt_count   <= '0;
         evt_period  <= '0;
         overrun     <= 1'b0;
      end else begin
         // prev tracks start_d even during clr so a level held high across
         // the clear is not seen as a fresh edge afterwards.
         prev <= start_d;
         if (clr) begin
            rise        <= 1'b0;
            total_count <= '0;
            evt_valid   <= 1'b0;
            evt_count   <= '0;
            evt_period  <= '0;
            overrun     <= 1'b0;
         end else begin
            rise <= edge_det;
            if (edge_det) begin
               total_count <= cnt_nx;
               // Load when empty or when the held record leaves this cycle.
               if (!evt_valid || hs) begin
                  evt_valid  <= 1'b1;
                  evt_count  <= cnt_nx;
                  evt_period <= offer_period;
               end else begin
                  overrun <= 1'b1;
               end
            end else if (hs) begin
               evt_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_start_edge_monitor.sv
module tb_start_edge_monitor;
   import start_mon_pkg::*;

`ifdef START_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        clr;
   logic        evt_ready;
   logic        evt_valid;
   logic [7:0]  evt_count;
   logic [15:0] evt_period;
   logic        rise;
   logic [7:0]  total_count;
   logic        overrun;

   // small-width instance for wrap and saturation
   logic        s_start;
   logic        s_clr;
   logic        s_ready;
   logic        s_valid;
   logic [3:0]  s_count;
   logic [3:0]  s_period;
   logic        s_rise;
   logic [3:0]  s_total;
   logic        s_overrun;

   int total;
   int bad;
   mon_evt_t sb[$];

   start_edge_monitor #(.CNT_W(8), .PER_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
      .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_count(evt_count),
      .evt_period(evt_period), .rise(rise), .total_count(total_count),
      .overrun(overrun)
   );

   start_edge_monitor #(.CNT_W(4), .PER_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .clr(s_clr),
      .evt_ready(s_ready), .evt_valid(s_valid), .evt_count(s_count),
      .evt_period(s_period), .rise(s_rise), .total_count(s_total),
      .overrun(s_overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard consumer: a handshake happens at the next posedge whenever
   // valid && ready are seen here (inputs only change just after posedge).
   always @(negedge clk) begin
      if (rst_n && !clr && evt_valid && evt_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got count=%0d period=%0d, required no event",
                     evt_count, evt_period);
         end else begin
            mon_evt_t exp_e;
            exp_e = sb.pop_front();
            if ({evt_count, evt_period} !== {exp_e.count, exp_e.period}) begin
               bad++;
               $display("FAIL event_record: got (%0d,%0d), required (%0d,%0d)",
                        evt_count, evt_period, exp_e.count, exp_e.period);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input int p);
      mon_evt_t e;
      e.count  = 8'(c);
      e.period = 16'(p);
      sb.push_back(e);
   endtask

   task automatic do_clr;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: %0d events outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      start     = 1'b1;
      evt_ready = 1'b1;
      tick(3);
      total++;
      if ({evt_valid, evt_count, evt_period, rise, total_count, overrun} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%b cnt=%0d per=%0d rise=%b total=%0d ovr=%b, required all 0",
                  evt_valid, evt_count, evt_period, rise, total_count, overrun);
      end
      push(1, 0);
      rst_n = 1'b1;
      for (int c = 1; c <= LAT; c++) begin
         tick();
         total++;
         if (rise !== (c == LAT)) begin
            bad++;
            $display("FAIL reset_first_rise cycle %0d: got %b, required %b", c, rise, c == LAT);
         end
      end
      start = 1'b0;
      drain("reset");
   endtask

   task automatic test_periodic;
      do_clr();
      evt_ready = 1'b1;
      push(1, 0); push(2, 4); push(3, 4); push(4, 4);
      for (int i = 0; i < 16 + LAT; i++) begin
         int j;
         start = (i < 16) && (i % 4 < 2);
         tick();
         j = i - (LAT - 1);
         total++;
         if (rise !== (j >= 0 && j < 16 && j % 4 == 0)) begin
            bad++;
            $display("FAIL periodic_rise i=%0d: got %b, required %b", i, rise,
                     j >= 0 && j < 16 && j % 4 == 0);
         end
      end
      total++;
      if (overrun !== 1'b0 || total_count !== 8'd4) begin
         bad++;
         $display("FAIL periodic_status: got ovr=%b total=%0d, required ovr=0 total=4",
                  overrun, total_count);
      end
      drain("periodic");
   endtask

   task automatic test_backpressure;
      do_clr();
      evt_ready = 1'b0;
      push(1, 0); push(4, 4);
      for (int i = 0; i < 16 + LAT; i++) begin
         start     = (i < 16) && (i % 4 < 2);
         evt_ready = (i >= 11);
         tick();
         if (i >= LAT - 1 && i <= 10) begin
            total++;
            if ({evt_valid, evt_count, evt_period} !== {1'b1, 8'd1, 16'd0}) begin
               bad++;
               $display("FAIL backpressure_hold i=%0d: got v=%b (%0d,%0d), required v=1 (1,0)",
                        i, evt_valid, evt_count, evt_period);
            end
         end
      end
      total++;
      if (overrun !== 1'b1 || total_count !== 8'd4) begin
         bad++;
         $display("FAIL backpressure_status: got ovr=%b total=%0d, required ovr=1 total=4",
                  overrun, total_count);
      end
      drain("backpressure");
   endtask

   task automatic test_simultaneous;
      do_clr();
      evt_ready = 1'b0;
      push(1, 0); push(2, 4);
      for (int i = 0; i < 8 + LAT; i++) begin
         start     = (i < 8) && (i % 4 < 2);
         evt_ready = (i >= LAT + 3);
         tick();
         if (i == LAT + 3) begin
            total++;
            if ({evt_valid, evt_count, evt_period, overrun} !== {1'b1, 8'd2, 16'd4, 1'b0}) begin
               bad++;
               $display("FAIL simultaneous_load: got v=%b (%0d,%0d) ovr=%b, required v=1 (2,4) ovr=0",
                        evt_valid, evt_count, evt_period, overrun);
            end
         end
      end
      drain("simultaneous");
   endtask

   task automatic test_clear;
      evt_ready = 1'b0;
      start     = 1'b1;
      tick(LAT);
      total++;
      if (evt_valid !== 1'b1) begin
         bad++;
         $display("FAIL clear_setup_valid: got %b, required 1", evt_valid);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      total++;
      if ({evt_valid, evt_count, evt_period, rise, total_count, overrun} !== '0) begin
         bad++;
         $display("FAIL clear_outputs: got v=%b cnt=%0d per=%0d rise=%b total=%0d ovr=%b, required all 0",
                  evt_valid, evt_count, evt_period, rise, total_count, overrun);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (rise !== 1'b0 || total_count !== 8'd0) begin
            bad++;
            $display("FAIL clear_no_edge i=%0d: got rise=%b total=%0d, required 0 0",
                     i, rise, total_count);
         end
      end
      start = 1'b0;
      tick(LAT + 1);
      push(1, 0);
      evt_ready = 1'b1;
      start     = 1'b1;
      tick(LAT);
      total++;
      if ({evt_valid, total_count} !== {1'b1, 8'd1}) begin
         bad++;
         $display("FAIL clear_restart: got v=%b total=%0d, required v=1 total=1",
                  evt_valid, total_count);
      end
      start = 1'b0;
      drain("clear");
   endtask

   task automatic test_wrap_sat;
      s_ready = 1'b1;
      for (int i = 0; i < 68; i++) begin
         s_start = (i % 4 < 2);
         tick();
      end
      tick(LAT);
      total++;
      if ({s_total, s_count, s_period} !== {4'd1, 4'd1, 4'd4}) begin
         bad++;
         $display("FAIL wrap_count: got total=%0d evt=(%0d,%0d), required total=1 evt=(1,4)",
                  s_total, s_count, s_period);
      end
      s_start = 1'b1;
      tick(2);
      s_start = 1'b0;
      tick(18);
      s_start = 1'b1;
      tick(LAT);
      total++;
      if ({s_count, s_period} !== {4'd3, 4'd15}) begin
         bad++;
         $display("FAIL period_saturate: got (%0d,%0d), required (3,15)", s_count, s_period);
      end
      s_start = 1'b0;
      tick(2);
   endtask

   task automatic test_reset_midrun;
      do_clr();
      evt_ready = 1'b0;
      for (int i = 0; i < 6 + LAT; i++) begin
         start = (i < 6) && (i % 4 < 2);
         tick();
      end
      total++;
      if ({evt_valid, overrun, total_count} !== {1'b1, 1'b1, 8'd2}) begin
         bad++;
         $display("FAIL midrun_setup: got v=%b ovr=%b total=%0d, required 1 1 2",
                  evt_valid, overrun, total_count);
      end
      rst_n = 1'b0;
      tick();
      total++;
      if ({evt_valid, evt_count, evt_period, rise, total_count, overrun} !== '0) begin
         bad++;
         $display("FAIL midrun_reset: got v=%b cnt=%0d per=%0d rise=%b total=%0d ovr=%b, required all 0",
                  evt_valid, evt_count, evt_period, rise, total_count, overrun);
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      clr     = 1'b0;
      evt_ready = 1'b0;
      s_start = 1'b0;
      s_clr   = 1'b0;
      s_ready = 1'b1;
      test_reset();
      test_periodic();
      test_backpressure();
      test_simultaneous();
      test_clear();
      test_wrap_sat();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
